// File: rtl/div_32bit_pkg.sv
// Shared constants and FSM state type for the 32-bit restoring divider.
package div_32bit_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ITER_LAST = 31;
  localparam int unsigned CNT_W     = $clog2(ITER_LAST + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LAST);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/div_32bit_sub.sv
// 33-bit trial subtractor: difference plus borrow out of the MSB.
module sub_33bit
  import div_32bit_pkg::*;
(
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] full;

  always_comb begin
    full   = {1'b0, minuend} - {1'b0, subtrahend};
    diff   = full[WIDTH:0];
    borrow = full[WIDTH+1];
  end

endmodule

// File: rtl/div_32bit.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle, MSB first.
module div_32bit
  import div_32bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               zdiv_q, zdiv_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic               unused_diff_msb;

  // The full 33-bit shifted remainder is used so a remainder with bit 31
  // set still divides correctly against divisors near 2^32.
  assign trial = {rem_q, dvd_q[WIDTH-1]};

  sub_33bit u_sub (
    .minuend    (trial),
    .subtrahend ({1'b0, dvs_q}),
    .diff       (diff),
    .borrow     (borrow)
  );

  // A successful trial is always below the divisor, so this bit is zero then.
  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    zdiv_d  = zdiv_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          zdiv_d  = (b == '0);
          state_d = (b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        // Quotient bits shift into the dividend register as it empties.
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        quo_d   = zdiv_q ? '1 : dvd_q;
        remo_d  = zdiv_q ? dvd_q : rem_q;
        dbz_d   = zdiv_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      zdiv_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      zdiv_q  <= zdiv_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit: vector table, corner sequences, random pairs.
module tb_div_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  always #5 clk = ~clk;

  div_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a_i),
    .b           (b_i),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned lat;
    int unsigned cyc0;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called in the negedge before the accepting edge.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz);
    exp_t e;
    e.q    = q;
    e.r    = r;
    e.dbz  = dbz;
    e.lat  = (b == 32'd0) ? 1 : 33;
    e.cyc0 = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dbz);
    @(negedge clk);
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    push_exp(a, b, q, r, dbz);
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
  endtask

  task automatic wait_done(input int unsigned max_cyc);
    bit   seen = 1'b0;
    exp_t e;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk1("done_seen", seen, 1'b1);
    if (!seen) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk1("unexpected_done", done, 1'b0);
    end else begin
      e = sb.pop_front();
      chk32("quotient", quotient, e.q);
      chk32("remainder", remainder, e.r);
      chk1("div_by_zero", div_by_zero, e.dbz);
      chk32("latency", 32'(cyc - e.cyc0), 32'(e.lat));
      chk1("busy_at_done", busy, 1'b0);
      @(negedge clk);
      chk1("done_width", done, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk32({tag, "_quotient"}, quotient, 32'd0);
    chk32({tag, "_remainder"}, remainder, 32'd0);
    chk1({tag, "_dbz"}, div_by_zero, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[2]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[3]  = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0};
    vecs[4]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[6]  = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    vecs[7]  = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0};
    vecs[8]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
    vecs[9]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[10] = '{32'd1000000,    32'd3,          32'd333333,     32'd1,          1'b0};
    vecs[11] = '{32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF,  1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // Start presented together with reset release is taken on the first edge.
    rst_n = 1'b1;
    start = 1'b1;
    a_i   = 32'd100;
    b_i   = 32'd7;
    push_exp(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    a_i   = 32'hA5A5_A5A5;
    b_i   = 32'd0;
    wait_done(60);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
      wait_done(60);
    end

    // Second start during a run must not disturb it or produce a second done.
    begin
      bit extra = 1'b0;
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (9) @(negedge clk);
      a_i   = 32'd9;
      b_i   = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(60);
      for (int unsigned i = 0; i < 45; i++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      end
      chk1("no_second_done", extra, 1'b0);
    end

    // Reset in the middle of a run aborts it and clears the outputs.
    begin
      bit stray = 1'b0;
      issue(32'd123456, 32'd789, 32'd156, 32'd372, 1'b0);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (done !== 1'b0) stray = 1'b1;
      end
      chk1("no_done_in_reset", stray, 1'b0);
      chk_reset_outputs("midrun_reset");
      sb.delete();
      rst_n = 1'b1;
      start = 1'b1;
      a_i   = 32'd50;
      b_i   = 32'd5;
      push_exp(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      a_i   = $urandom;
      b_i   = $urandom;
      wait_done(60);
    end

    for (int unsigned n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      issue(ra, rb, ra / rb, ra % rb, 1'b0);
      wait_done(60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
